// File: rtl/idma_nd_req_arbiter.sv
// Round-robin arbiter sharing one ND midend among several ND requesters. A grant is held for the
// whole ND transfer, and last-responses are routed back in acceptance order.
module idma_nd_req_arbiter #(
   parameter int unsigned NumInp        = 2,
   parameter int unsigned TrackDepth    = 4,
   parameter type         idma_nd_req_t = logic,
   parameter type         idma_rsp_t    = logic
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  idma_nd_req_t      inp_nd_req_i       [NumInp],
   input  logic [NumInp-1:0] inp_nd_req_valid_i,
   output logic [NumInp-1:0] inp_nd_req_ready_o,
   output idma_rsp_t         inp_nd_rsp_o       [NumInp],
   output logic [NumInp-1:0] inp_nd_rsp_valid_o,
   input  logic [NumInp-1:0] inp_nd_rsp_ready_i,
   output idma_nd_req_t      oup_nd_req_o,
   output logic              oup_nd_req_valid_o,
   input  logic              oup_nd_req_ready_i,
   input  idma_rsp_t         oup_nd_rsp_i,
   input  logic              oup_nd_rsp_valid_i,
   output logic              oup_nd_rsp_ready_o,
   output logic              busy_o
);

   localparam int unsigned IdxWidth = $clog2(NumInp);
   localparam int unsigned SumW     = IdxWidth + 1;
   localparam int unsigned CntWidth = $clog2(TrackDepth + 1);
   localparam int unsigned PtrWidth = (TrackDepth > 1) ? $clog2(TrackDepth) : 1;

   localparam logic [0:0] StIdle   = 1'b0;
   localparam logic [0:0] StLocked = 1'b1;

   if (NumInp < 2) begin : gen_num_inp_check
      $fatal(1, "idma_nd_req_arbiter: NumInp must be at least 2");
   end
   if (TrackDepth < 1) begin : gen_track_depth_check
      $fatal(1, "idma_nd_req_arbiter: TrackDepth must be at least 1");
   end

   function automatic logic [IdxWidth-1:0] idx_inc(logic [IdxWidth-1:0] v);
      return (v == IdxWidth'(NumInp - 1)) ? '0 : v + 1'b1;
   endfunction

   function automatic logic [PtrWidth-1:0] ptr_inc(logic [PtrWidth-1:0] v);
      return (v == PtrWidth'(TrackDepth - 1)) ? '0 : v + 1'b1;
   endfunction

   logic [0:0]          state_q, state_d;
   logic [IdxWidth-1:0] rr_q, rr_d;
   logic [IdxWidth-1:0] grant_q, grant_d;
   logic [IdxWidth-1:0] fifo_q [TrackDepth];
   logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntWidth-1:0] count_q, count_d;

   logic                fifo_full, fifo_empty;
   logic                cand_found;
   logic [IdxWidth-1:0] cand_idx;
   logic [SumW-1:0]     scan_sum;
   logic                push, pop, do_write, do_read;
   logic [IdxWidth-1:0] push_idx;
   logic                head_valid;
   logic [IdxWidth-1:0] head_idx;
   logic [NumInp-1:0]   req_ready;
   logic [NumInp-1:0]   rsp_valid;
   logic                rsp_ready;
   logic                oup_valid;

   assign fifo_full  = (count_q == CntWidth'(TrackDepth));
   assign fifo_empty = (count_q == '0);

   // First valid requester at or after rr_q, wrapping at NumInp.
   always_comb begin
      cand_found = 1'b0;
      cand_idx   = '0;
      scan_sum   = '0;
      for (int unsigned off = 0; off < NumInp; off++) begin
         scan_sum = {1'b0, rr_q} + SumW'(off);
         if (scan_sum >= SumW'(NumInp)) begin
            scan_sum = scan_sum - SumW'(NumInp);
         end
         if (!cand_found && inp_nd_req_valid_i[scan_sum[IdxWidth-1:0]]) begin
            cand_found = 1'b1;
            cand_idx   = scan_sum[IdxWidth-1:0];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      rr_d         = rr_q;
      grant_d      = grant_q;
      req_ready    = '0;
      push         = 1'b0;
      push_idx     = '0;
      oup_nd_req_o = '0;
      oup_valid    = 1'b0;
      case (state_q)
         StIdle: begin
            if (!fifo_full && cand_found) begin
               oup_nd_req_o = inp_nd_req_i[cand_idx];
               oup_valid    = 1'b1;
               if (oup_nd_req_ready_i) begin
                  req_ready[cand_idx] = 1'b1;
                  push                = 1'b1;
                  push_idx            = cand_idx;
                  rr_d                = idx_inc(cand_idx);
               end else begin
                  grant_d = cand_idx;
                  state_d = StLocked;
               end
            end
         end
         StLocked: begin
            // Midend raises ready only on its last burst; hold the grant until then.
            oup_nd_req_o = inp_nd_req_i[grant_q];
            oup_valid    = inp_nd_req_valid_i[grant_q];
            if (oup_valid && oup_nd_req_ready_i) begin
               req_ready[grant_q] = 1'b1;
               push               = 1'b1;
               push_idx           = grant_q;
               rr_d               = idx_inc(grant_q);
               state_d            = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Fall-through head lets a zero-repetition transfer be answered in its acceptance cycle.
   always_comb begin
      head_valid = ~fifo_empty | push;
      head_idx   = fifo_empty ? push_idx : fifo_q[rd_ptr_q];
      rsp_valid  = '0;
      if (head_valid) begin
         rsp_valid[head_idx] = oup_nd_rsp_valid_i;
      end
      rsp_ready = head_valid & inp_nd_rsp_ready_i[head_idx];
   end

   assign pop      = oup_nd_rsp_valid_i & rsp_ready;
   assign do_write = push & ~(fifo_empty & pop);
   assign do_read  = pop & ~fifo_empty;
   assign count_d  = count_q + CntWidth'(do_write) - CntWidth'(do_read);

   always_comb begin
      for (int i = 0; i < NumInp; i++) begin
         inp_nd_rsp_o[i] = oup_nd_rsp_i;
      end
   end

   assign oup_nd_req_valid_o = rst_ni & oup_valid;
   assign inp_nd_req_ready_o = rst_ni ? req_ready : '0;
   assign inp_nd_rsp_valid_o = rst_ni ? rsp_valid : '0;
   assign oup_nd_rsp_ready_o = rst_ni & rsp_ready;
   assign busy_o             = rst_ni & ((state_q == StLocked) | ~fifo_empty);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         rr_q     <= '0;
         grant_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < TrackDepth; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         grant_q <= grant_d;
         count_q <= count_d;
         if (do_write) begin
            fifo_q[wr_ptr_q] <= push_idx;
            wr_ptr_q         <= ptr_inc(wr_ptr_q);
         end
         if (do_read) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (rst_ni && oup_nd_rsp_valid_i) begin
         assert (head_valid)
            else $error("idma_nd_req_arbiter: response with no outstanding transfer");
      end
      if (rst_ni && do_write) begin
         assert (!fifo_full || do_read)
            else $error("idma_nd_req_arbiter: tracking FIFO overflow");
      end
   end
`endif

endmodule

// File: tb/tb_idma_nd_req_arbiter.sv
// Self-checking bench for idma_nd_req_arbiter: per-cycle vector table plus a response-routing
// scoreboard, followed by a hand-written asynchronous reset sequence.
module tb_idma_nd_req_arbiter;

   localparam int unsigned NumInp     = 3;
   localparam int unsigned TrackDepth = 2;

   typedef logic [15:0] req_t;
   typedef logic [7:0]  rsp_t;

   logic              clk = 1'b0;
   logic              rst_n;
   req_t              inp_nd_req       [NumInp];
   logic [NumInp-1:0] inp_nd_req_valid;
   logic [NumInp-1:0] inp_nd_req_ready;
   rsp_t              inp_nd_rsp       [NumInp];
   logic [NumInp-1:0] inp_nd_rsp_valid;
   logic [NumInp-1:0] inp_nd_rsp_ready;
   req_t              oup_nd_req;
   logic              oup_nd_req_valid;
   logic              oup_nd_req_ready;
   rsp_t              oup_nd_rsp;
   logic              oup_nd_rsp_valid;
   logic              oup_nd_rsp_ready;
   logic              busy;

   always #5 clk = ~clk;

   idma_nd_req_arbiter #(
      .NumInp       (NumInp),
      .TrackDepth   (TrackDepth),
      .idma_nd_req_t(req_t),
      .idma_rsp_t   (rsp_t)
   ) dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .inp_nd_req_i      (inp_nd_req),
      .inp_nd_req_valid_i(inp_nd_req_valid),
      .inp_nd_req_ready_o(inp_nd_req_ready),
      .inp_nd_rsp_o      (inp_nd_rsp),
      .inp_nd_rsp_valid_o(inp_nd_rsp_valid),
      .inp_nd_rsp_ready_i(inp_nd_rsp_ready),
      .oup_nd_req_o      (oup_nd_req),
      .oup_nd_req_valid_o(oup_nd_req_valid),
      .oup_nd_req_ready_i(oup_nd_req_ready),
      .oup_nd_rsp_i      (oup_nd_rsp),
      .oup_nd_rsp_valid_i(oup_nd_rsp_valid),
      .oup_nd_rsp_ready_o(oup_nd_rsp_ready),
      .busy_o            (busy)
   );

   // acc: index accepted this cycle (-1 none); src: index on oup request (-1 no valid).
   typedef struct {
      logic [2:0] rv;
      logic       orr;
      logic       sv;
      logic [2:0] sr;
      int         acc;
      int         src;
      logic       busy;
   } vec_t;

   vec_t vecs[$];
   int   sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(logic [2:0] rv, logic orr, logic sv, logic [2:0] sr, int acc,
                               int src, logic bsy);
      vec_t v;
      v.rv   = rv;
      v.orr  = orr;
      v.sv   = sv;
      v.sr   = sr;
      v.acc  = acc;
      v.src  = src;
      v.busy = bsy;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] rv, input logic orr, input logic sv,
                        input logic [2:0] sr);
      inp_nd_req_valid = rv;
      oup_nd_req_ready = orr;
      oup_nd_rsp_valid = sv;
      inp_nd_rsp_ready = sr;
   endtask

   vec_t       v;
   int         last_acc;
   int         head;
   logic       hv;
   logic [2:0] exp_req_ready;
   logic [2:0] exp_rsp_valid;
   logic       exp_rsp_ready;
   rsp_t       rsp_val;

   initial begin
      rst_n = 1'b0;
      drive(3'b000, 1'b0, 1'b0, 3'b111);
      oup_nd_rsp = '0;
      for (int i = 0; i < NumInp; i++) begin
         inp_nd_req[i] = req_t'(16'h1000 * (i + 1));
      end
      repeat (2) @(posedge clk);
      #1;
      drive(3'b111, 1'b1, 1'b0, 3'b111);
      #1;
      chk("init_rst oup_valid", 32'(oup_nd_req_valid), 32'd0);
      chk("init_rst req_ready", 32'(inp_nd_req_ready), 32'd0);
      chk("init_rst busy", 32'(busy), 32'd0);
      drive(3'b000, 1'b0, 1'b0, 3'b111);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      vecs.push_back(mk(3'b000, 0, 0, 3'b111, -1, -1, 0));
      // Lock: req0 held against req1 until the midend is ready
      vecs.push_back(mk(3'b011, 0, 0, 3'b111, -1, 0, 0));
      for (int i = 0; i < 5; i++) vecs.push_back(mk(3'b011, 0, 0, 3'b111, -1, 0, 1));
      vecs.push_back(mk(3'b011, 1, 0, 3'b111, 0, 0, 1));
      vecs.push_back(mk(3'b010, 0, 0, 3'b111, -1, 1, 1));
      vecs.push_back(mk(3'b010, 1, 0, 3'b111, 1, 1, 1));
      // Back-pressure: FIFO full, response stalled by ready_i[0]=0, then a pop frees a slot
      vecs.push_back(mk(3'b001, 1, 0, 3'b110, -1, -1, 1));
      vecs.push_back(mk(3'b001, 1, 1, 3'b110, -1, -1, 1));
      vecs.push_back(mk(3'b001, 1, 1, 3'b111, -1, -1, 1));
      vecs.push_back(mk(3'b001, 1, 0, 3'b111, 0, 0, 1));
      vecs.push_back(mk(3'b000, 0, 1, 3'b111, -1, -1, 1));
      vecs.push_back(mk(3'b000, 0, 1, 3'b111, -1, -1, 1));
      vecs.push_back(mk(3'b000, 0, 0, 3'b111, -1, -1, 0));
      // Single requester, multi-cycle transfer then delayed response
      vecs.push_back(mk(3'b001, 0, 0, 3'b111, -1, 0, 0));
      for (int i = 0; i < 3; i++) vecs.push_back(mk(3'b001, 0, 0, 3'b111, -1, 0, 1));
      vecs.push_back(mk(3'b001, 1, 0, 3'b111, 0, 0, 1));
      for (int i = 0; i < 3; i++) vecs.push_back(mk(3'b000, 0, 0, 3'b111, -1, -1, 1));
      vecs.push_back(mk(3'b000, 0, 1, 3'b111, -1, -1, 1));
      vecs.push_back(mk(3'b000, 0, 0, 3'b111, -1, -1, 0));
      // Zero-repetition transfer answered in its acceptance cycle
      vecs.push_back(mk(3'b100, 1, 1, 3'b111, 2, 2, 0));
      vecs.push_back(mk(3'b000, 0, 0, 3'b111, -1, -1, 0));
      // Fairness: all valid, one acceptance per cycle in rotation
      for (int i = 0; i < 6; i++) vecs.push_back(mk(3'b111, 1, 1, 3'b111, i % 3, i % 3, 0));
      vecs.push_back(mk(3'b000, 0, 0, 3'b111, -1, -1, 0));

      last_acc = -1;
      for (int k = 0; k < vecs.size(); k++) begin
         v = vecs[k];
         @(posedge clk);
         #1;
         if (last_acc >= 0) inp_nd_req[last_acc] = inp_nd_req[last_acc] + 1'b1;
         drive(v.rv, v.orr, v.sv, v.sr);
         rsp_val    = rsp_t'(8'h30 + k);
         oup_nd_rsp = rsp_val;
         #2;
         if (v.acc >= 0) sb.push_back(v.acc);
         hv            = (sb.size() != 0);
         head          = hv ? sb[0] : 0;
         exp_rsp_ready = hv && v.sr[head];
         exp_rsp_valid = (v.sv && hv) ? (3'b001 << head) : 3'b000;
         exp_req_ready = (v.acc >= 0) ? (3'b001 << v.acc) : 3'b000;
         chk($sformatf("v%0d req_ready", k), 32'(inp_nd_req_ready), 32'(exp_req_ready));
         chk($sformatf("v%0d oup_valid", k), 32'(oup_nd_req_valid), 32'(v.src >= 0));
         if (v.src >= 0) begin
            chk($sformatf("v%0d oup_req", k), 32'(oup_nd_req), 32'(inp_nd_req[v.src]));
         end
         chk($sformatf("v%0d rsp_valid", k), 32'(inp_nd_rsp_valid), 32'(exp_rsp_valid));
         chk($sformatf("v%0d rsp_ready", k), 32'(oup_nd_rsp_ready), 32'(exp_rsp_ready));
         chk($sformatf("v%0d busy", k), 32'(busy), 32'(v.busy));
         if (v.sv) begin
            for (int i = 0; i < NumInp; i++) begin
               chk($sformatf("v%0d rsp_data%0d", k, i), 32'(inp_nd_rsp[i]), 32'(rsp_val));
            end
         end
         if (v.sv && exp_rsp_ready) void'(sb.pop_front());
         last_acc = v.acc;
      end

      // Reset in the middle of a locked transfer: rr pointer and FIFO must restart.
      @(posedge clk);
      #1;
      if (last_acc >= 0) inp_nd_req[last_acc] = inp_nd_req[last_acc] + 1'b1;
      drive(3'b010, 1'b1, 1'b0, 3'b111);
      #2;
      chk("rs0 req_ready", 32'(inp_nd_req_ready), 32'b010);
      @(posedge clk);
      #1;
      inp_nd_req[1] = inp_nd_req[1] + 1'b1;
      drive(3'b100, 1'b0, 1'b0, 3'b111);
      #2;
      chk("rs1 oup_req", 32'(oup_nd_req), 32'(inp_nd_req[2]));
      chk("rs1 oup_valid", 32'(oup_nd_req_valid), 32'd1);
      repeat (2) begin
         @(posedge clk);
         #3;
         chk("rs_lock oup_req", 32'(oup_nd_req), 32'(inp_nd_req[2]));
         chk("rs_lock busy", 32'(busy), 32'd1);
      end
      #1;
      drive(3'b111, 1'b1, 1'b0, 3'b111);
      rst_n = 1'b0;
      #1;
      chk("rs_mid oup_valid", 32'(oup_nd_req_valid), 32'd0);
      chk("rs_mid busy", 32'(busy), 32'd0);
      chk("rs_mid req_ready", 32'(inp_nd_req_ready), 32'd0);
      chk("rs_mid rsp_ready", 32'(oup_nd_rsp_ready), 32'd0);
      @(posedge clk);
      #1;
      oup_nd_req_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rs_post oup_req", 32'(oup_nd_req), 32'(inp_nd_req[0]));
      chk("rs_post oup_valid", 32'(oup_nd_req_valid), 32'd1);
      chk("rs_post busy", 32'(busy), 32'd0);
      chk("rs_post req_ready", 32'(inp_nd_req_ready), 32'd0);
      @(posedge clk);
      #1;
      oup_nd_req_ready = 1'b1;
      #1;
      chk("rs_acc req_ready", 32'(inp_nd_req_ready), 32'b001);
      chk("rs_acc busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      drive(3'b000, 1'b0, 1'b1, 3'b111);
      #1;
      chk("rs_rsp rsp_valid", 32'(inp_nd_rsp_valid), 32'b001);
      chk("rs_rsp rsp_ready", 32'(oup_nd_rsp_ready), 32'd1);
      @(posedge clk);
      #1;
      drive(3'b000, 1'b0, 1'b0, 3'b111);
      #1;
      chk("rs_end busy", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
